scc_data_responder: RTL

Data-memory responder for the single-cycle core's data port: it serves every load and store issued on `data_addr`/`data_wdata`/`data_wenable`/`data_rdata`. It decodes the address into a word RAM and a small MMIO window. The window holds a console transmit FIFO, drained through a valid/ready byte stream, and a free-running cycle counter. Reads are combinational and complete in the core's single cycle; writes commit on the next rising clock edge.

---
 rtl/scc_data_responder_if.sv | 20 ++
 rtl/scc_data_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/scc_data_responder_if.sv
// Data-port and console-stream signals between the core side and the data responder.
interface scc_data_responder_if;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wenable;
   logic [31:0] data_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output data_addr, data_wdata, data_wenable, tx_ready,
      input  data_rdata, tx_data, tx_valid
   );

   modport slave (
      input  data_addr, data_wdata, data_wenable, tx_ready,
      output data_rdata, tx_data, tx_valid
   );
endinterface

// File: rtl/scc_data_responder.sv
// Single-cycle core data-port responder: word RAM plus MMIO window holding a
// console transmit FIFO (valid/ready byte stream) and a free-running cycle counter.
module scc_data_responder #(
   parameter int unsigned RAM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   scc_data_responder_if.slave bus
);
   localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
   localparam int unsigned PW     = $clog2(FIFO_DEPTH);
   localparam int unsigned CW     = PW + 1;

   logic [31:0] r_ram [RAM_WORDS];
   logic [7:0]  r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic          r_tx_valid;
   logic [7:0]    r_tx_data;
   logic [31:0]   r_cycle;

   logic [1:0]        w_off;
   logic [1:0]        w_sel;
   logic              w_is_ram;
   logic              w_is_mmio;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [31:0]       w_ram_word;
   logic [3:0]        w_lane;
   logic [31:0]       w_wdata_sh;
   logic              w_ram_we;
   logic              w_mmio_we;
   logic              w_empty, w_full;
   logic              w_push_req, w_push, w_pop;
   logic              w_ovf_set, w_ovf_clr;
   logic [CW-1:0]     w_cnt_after_pop, w_count_n;
   logic [PW-1:0]     w_rptr_n;
   logic [7:0]        w_head_n;
   logic [31:0]       w_rdata;

   // Address decode
   assign w_off      = bus.data_addr[1:0];
   assign w_sel      = bus.data_addr[3:2];
   assign w_is_ram   = ~bus.data_addr[31] && ({3'b000, bus.data_addr[30:2]} < 32'(RAM_WORDS));
   assign w_is_mmio  = (bus.data_addr[31:4] == 28'h800_0000);
   assign w_ram_idx  = bus.data_addr[RAM_AW+1:2];
   assign w_ram_word = r_ram[w_ram_idx];

   // Lanes shifted past byte 3 fall off the 4-bit mask, so nothing spills into the next word
   assign w_lane     = bus.data_wenable << w_off;
   assign w_wdata_sh = bus.data_wdata << {w_off, 3'b000};
   assign w_ram_we   = w_is_ram && !rst;
   assign w_mmio_we  = w_is_mmio && (bus.data_wenable != 4'b0000) && !rst;

   // FIFO control
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_pop      = r_tx_valid && bus.tx_ready;
   assign w_push_req = w_mmio_we && (w_sel == 2'd0);
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;
   assign w_ovf_clr  = w_mmio_we && (w_sel == 2'd1) && bus.data_wdata[2];

   assign w_cnt_after_pop = r_count - CW'(w_pop);
   assign w_count_n       = w_cnt_after_pop + CW'(w_push);
   assign w_rptr_n        = r_rptr + PW'(w_pop);
   // A push into a queue left empty by this cycle becomes the new head directly
   assign w_head_n        = (w_cnt_after_pop == '0) ? bus.data_wdata[7:0] : r_fifo[w_rptr_n];

   // Combinational load path
   always_comb begin
      w_rdata = '0;
      if (w_is_ram) begin
         w_rdata = w_ram_word >> {w_off, 3'b000};
      end else if (w_is_mmio) begin
         case (w_sel)
            2'd1:    w_rdata = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};
            2'd2:    w_rdata = r_cycle;
            default: w_rdata = '0;
         endcase
      end
   end

   assign bus.data_rdata = w_rdata;
   assign bus.tx_data    = r_tx_data;
   assign bus.tx_valid   = r_tx_valid;

   // RAM byte-lane writes; contents survive reset
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int k = 0; k < 4; k++) begin
            if (w_lane[k]) r_ram[w_ram_idx][8*k +: 8] <= w_wdata_sh[8*k +: 8];
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr] <= bus.data_wdata[7:0];
   end

   // FIFO pointers, status, stream outputs and cycle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_cycle    <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         r_rptr     <= w_rptr_n;
         r_count    <= w_count_n;
         r_ovf      <= (r_ovf | w_ovf_set) & ~w_ovf_clr;
         r_tx_valid <= (w_count_n != '0);
         if (w_count_n != '0) r_tx_data <= w_head_n;
         if (w_mmio_we && (w_sel == 2'd2)) r_cycle <= bus.data_wdata;
         else                              r_cycle <= r_cycle + 32'd1;
      end
   end
endmodule
